// File: rtl/cdm_8_62.sv
// cdm_8_62: 8x8 unsigned carry-disregard approximate multiplier, registered output.
//
// The six least-significant partial-product columns (weights 0..5) are reduced by
// parity only, so no carries leave them. Columns 6..14 are summed exactly through
// a carry-save tree and one final adder. Because the exact upper sum is always a
// multiple of 64, the two regions never overlap and merge with a plain OR.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   A         in   8   unsigned multiplicand
//   B         in   8   unsigned multiplier
//   in_valid  in   1   A/B are qualified this cycle
//   R         out 16   approximate product (registered, held when in_valid is low)
//   out_valid out  1   R was loaded from a qualified input on the last edge

module cdm_8_62 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        in_valid,
    output logic [15:0] R,
    output logic        out_valid
);

    // Keeps only weights 6..15 of a shifted partial-product row.
    localparam logic [15:0] HiMask = 16'hFFC0;

    // 3:2 compressor over 16-bit vectors; sum + carry equals a + b + c (mod 2^16),
    // which is exact here because the true total never reaches 2^16.
    function automatic logic [15:0] csa_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [15:0] csa_carry(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic [7:0]  pp [8];        // pp[i][j] = A[j] & B[i], weight i+j
    logic [15:0] row_hi [8];    // row i shifted to weight, low region cleared
    logic [5:0]  f_low;         // parity of each approximate column
    logic [15:0] s1a, c1a, s1b, c1b;
    logic [15:0] s2a, c2a, s2b, c2b;
    logic [15:0] s3, c3;
    logic [15:0] s4, c4;
    logic [15:0] u_hi;
    logic [15:0] r_d, r_q;
    logic        valid_d, valid_q;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = A & {8{B[i]}};
        end
    end

    // Approximate region: each column collapses to the XOR of its bits.
    always_comb begin
        f_low = '0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j <= k; j++) begin
                f_low[k] = f_low[k] ^ pp[k - j][j];
            end
        end
    end

    // Exact region: only bits of weight >= 6 enter the tree.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row_hi[i] = (16'(pp[i]) << i) & HiMask;
        end
    end

    // Carry-save reduction: 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    always_comb begin
        s1a = csa_sum(row_hi[0], row_hi[1], row_hi[2]);
        c1a = csa_carry(row_hi[0], row_hi[1], row_hi[2]);
        s1b = csa_sum(row_hi[3], row_hi[4], row_hi[5]);
        c1b = csa_carry(row_hi[3], row_hi[4], row_hi[5]);

        s2a = csa_sum(s1a, c1a, s1b);
        c2a = csa_carry(s1a, c1a, s1b);
        s2b = csa_sum(c1b, row_hi[6], row_hi[7]);
        c2b = csa_carry(c1b, row_hi[6], row_hi[7]);

        s3  = csa_sum(s2a, c2a, s2b);
        c3  = csa_carry(s2a, c2a, s2b);

        s4  = csa_sum(s3, c3, c2b);
        c4  = csa_carry(s3, c3, c2b);

        u_hi = s4 + c4;
    end

    // Result register holds its value on idle cycles; only the valid flag drops.
    always_comb begin
        r_d     = r_q;
        valid_d = 1'b0;
        if (in_valid) begin
            r_d     = u_hi | {10'b0, f_low};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            valid_q <= valid_d;
        end
    end

    assign R         = r_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cdm_8_62.sv
// Self-checking bench for cdm_8_62: directed cases, valid gating, pipelining,
// asynchronous reset and an exhaustive sweep against an independent model.

module tb_cdm_8_62;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic        vld;
    logic [15:0] r_o;
    logic        ov_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic        v;
        logic [15:0] r;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_r = '0;

    cdm_8_62 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a_s),
        .B         (b_s),
        .in_valid  (vld),
        .R         (r_o),
        .out_valid (ov_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product minus the exact contribution of columns 0..5, plus their parities.
    function automatic int unsigned model(input logic [7:0] a, input logic [7:0] b);
        int unsigned low_exact = 0;
        int unsigned par       = 0;
        for (int k = 0; k < 6; k++) begin
            int unsigned cnt = 0;
            for (int j = 0; j <= k; j++) begin
                cnt += (a[j] & b[k - j]) ? 1 : 0;
            end
            low_exact += cnt << k;
            par       += (cnt & 1) << k;
        end
        return int'(a) * int'(b) - low_exact + par;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle (called at negedge), then compare the registered result.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v,
                         input string tag);
        exp_t e;
        a_s = a;
        b_s = b;
        vld = v;
        if (v) exp_r = 16'(model(a, b));
        sb.push_back('{v, exp_r, tag});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty got %0d expected entry", tag, r_o);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (ov_o === e.v) else begin
                errors++;
                $error("FAIL %s_valid got %0b expected %0b", e.tag, ov_o, e.v);
            end
            checks++;
            assert (r_o === e.r) else begin
                errors++;
                $error("FAIL %s_r got %0d expected %0d", e.tag, r_o, e.r);
            end
        end
    endtask

    initial begin
        int unsigned prod;
        rst_n = 1'b0;
        a_s   = '0;
        b_s   = '0;
        vld   = 1'b0;
        #3;
        check_val("reset_r", 32'(r_o), 32'd0);
        check_val("reset_valid", 32'(ov_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact cases
        drive(8'd0, 8'd200, 1'b1, "a0_b200");    check_val("c_a0_b200", 32'(r_o), 32'd0);
        drive(8'd1, 8'd173, 1'b1, "a1_b173");    check_val("c_a1_b173", 32'(r_o), 32'd173);
        drive(8'd64, 8'd64, 1'b1, "a64_b64");    check_val("c_a64_b64", 32'(r_o), 32'd4096);
        drive(8'd128, 8'd2, 1'b1, "a128_b2");    check_val("c_a128_b2", 32'(r_o), 32'd256);

        // Approximate cases
        drive(8'd15, 8'd15, 1'b1, "a15_b15");    check_val("c_a15_b15", 32'(r_o), 32'd85);
        drive(8'd3, 8'd3, 1'b1, "a3_b3");        check_val("c_a3_b3", 32'(r_o), 32'd5);

        // Valid gating: R holds, valid drops
        drive(8'd255, 8'd255, 1'b1, "a255_b255"); check_val("c_a255", 32'(r_o), 32'd64725);
        drive(8'd1, 8'd1, 1'b0, "gate");          check_val("c_gate_hold", 32'(r_o), 32'd64725);
        check_val("c_gate_valid", 32'(ov_o), 32'd0);

        // Asynchronous reset mid-cycle with R nonzero
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_r", 32'(r_o), 32'd0);
        check_val("async_reset_valid", 32'(ov_o), 32'd0);
        exp_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd3, 8'd3, 1'b1, "post_reset");   check_val("c_post_reset", 32'(r_o), 32'd5);

        // Pipelining: back-to-back valid inputs
        drive(8'd3, 8'd3, 1'b1, "pipe0");        check_val("c_pipe0", 32'(r_o), 32'd5);
        drive(8'd15, 8'd15, 1'b1, "pipe1");      check_val("c_pipe1", 32'(r_o), 32'd85);
        drive(8'd1, 8'd7, 1'b1, "pipe2");        check_val("c_pipe2", 32'(r_o), 32'd7);

        // Exhaustive sweep with symmetry and error-bound checks on the DUT output
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(8'(a), 8'(b), 1'b1, "exh");
                prod = 32'(a * b);
                checks++;
                assert (32'(r_o) === model(8'(b), 8'(a))) else begin
                    errors++;
                    $error("FAIL exh_sym a=%0d b=%0d got %0d expected %0d", a, b, r_o,
                           model(8'(b), 8'(a)));
                end
                checks++;
                assert ((32'(r_o) <= prod) && ((prod - 32'(r_o)) <= 300)
                        && (((prod - 32'(r_o)) % 2) == 0)) else begin
                    errors++;
                    $error("FAIL exh_err a=%0d b=%0d got %0d expected within 0..300 below %0d",
                           a, b, r_o, prod);
                end
            end
        end

        vld = 1'b0;
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
